// File: rtl/axi_sevenseg_slave_if.sv
// AXI4-Lite bus bundle between a master and the seven-segment display slave.
interface axi_sevenseg_slave_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_sevenseg_slave.sv
// AXI4-Lite register slave that scans four digits onto a multiplexed
// active-low seven-segment display (hex decode or raw segment patterns).
module axi_sevenseg_slave #(
  parameter int C_S00_AXI_DATA_WIDTH = 32,
  parameter int C_S00_AXI_ADDR_WIDTH = 4
) (
  input  logic                s00_axi_aclk,
  input  logic                s00_axi_areset,
  axi_sevenseg_slave_if.slave s00_axi,
  output logic [7:0]          sieteseg,
  output logic [3:0]          anodes
);

  logic        wr_ready;
  logic        bvalid_q;
  logic        arready_q;
  logic        rvalid_q;
  logic [C_S00_AXI_DATA_WIDTH-1:0] rdata_q;
  logic [C_S00_AXI_DATA_WIDTH-1:0] rd_mux;

  logic        ctrl_en;
  logic        ctrl_raw;
  logic [3:0]  ctrl_dp;
  logic [31:0] digits;
  logic [15:0] prescale;
  logic [7:0]  wr_count;
  logic [15:0] scan_cnt;
  logic [1:0]  digit;

  logic [1:0]  waddr;
  logic [1:0]  raddr;
  logic        wr_fire;
  logic        rd_fire;
  logic [3:0]  cur_nib;
  logic [7:0]  cur_byte;
  logic [7:0]  hex_pat;
  logic [7:0]  pattern;
  logic        unused_bits;

  assign waddr   = s00_axi.awaddr[C_S00_AXI_ADDR_WIDTH-1:2];
  assign raddr   = s00_axi.araddr[C_S00_AXI_ADDR_WIDTH-1:2];
  assign wr_fire = wr_ready & s00_axi.awvalid & s00_axi.wvalid;
  assign rd_fire = arready_q & s00_axi.arvalid;

  assign s00_axi.awready = wr_ready;
  assign s00_axi.wready  = wr_ready;
  assign s00_axi.bresp   = 2'b00;
  assign s00_axi.bvalid  = bvalid_q;
  assign s00_axi.arready = arready_q;
  assign s00_axi.rdata   = rdata_q;
  assign s00_axi.rresp   = 2'b00;
  assign s00_axi.rvalid  = rvalid_q;

  assign unused_bits = ^{s00_axi.awprot, s00_axi.arprot,
                         s00_axi.awaddr[1:0], s00_axi.araddr[1:0]};

  // Address and data are accepted together, only once the previous response is gone.
  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      wr_ready <= 1'b0;
      bvalid_q <= 1'b0;
    end else begin
      wr_ready <= !wr_ready && s00_axi.awvalid && s00_axi.wvalid && !bvalid_q;
      if (wr_fire)
        bvalid_q <= 1'b1;
      else if (s00_axi.bready)
        bvalid_q <= 1'b0;
    end
  end

  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      ctrl_en  <= 1'b0;
      ctrl_raw <= 1'b0;
      ctrl_dp  <= 4'h0;
      digits   <= 32'h0;
      prescale <= 16'h0;
      wr_count <= 8'h0;
    end else if (wr_fire) begin
      wr_count <= wr_count + 8'd1;
      case (waddr)
        2'd0: if (s00_axi.wstrb[0]) begin
          ctrl_en  <= s00_axi.wdata[0];
          ctrl_raw <= s00_axi.wdata[1];
          ctrl_dp  <= s00_axi.wdata[7:4];
        end
        2'd1: for (int b = 0; b < 4; b++)
          if (s00_axi.wstrb[b]) digits[8*b +: 8] <= s00_axi.wdata[8*b +: 8];
        2'd2: for (int b = 0; b < 2; b++)
          if (s00_axi.wstrb[b]) prescale[8*b +: 8] <= s00_axi.wdata[8*b +: 8];
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_mux = '0;
    case (raddr)
      2'd0: rd_mux = {24'h0, ctrl_dp, 2'b00, ctrl_raw, ctrl_en};
      2'd1: rd_mux = digits;
      2'd2: rd_mux = {16'h0, prescale};
      2'd3: rd_mux = {16'h0, wr_count, 6'h0, digit};
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      arready_q <= !arready_q && s00_axi.arvalid && !rvalid_q;
      if (rd_fire) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_mux;
      end else if (s00_axi.rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      scan_cnt <= 16'h0;
      digit    <= 2'd0;
    end else if (ctrl_en) begin
      if (scan_cnt == prescale) begin
        scan_cnt <= 16'h0;
        digit    <= digit + 2'd1;
      end else begin
        scan_cnt <= scan_cnt + 16'd1;
      end
    end
  end

  assign cur_nib  = digits[4*digit +: 4];
  assign cur_byte = digits[8*digit +: 8];

  always_comb begin
    hex_pat = 8'hFF;
    case (cur_nib)
      4'h0: hex_pat = 8'hC0;
      4'h1: hex_pat = 8'hF9;
      4'h2: hex_pat = 8'hA4;
      4'h3: hex_pat = 8'hB0;
      4'h4: hex_pat = 8'h99;
      4'h5: hex_pat = 8'h92;
      4'h6: hex_pat = 8'h82;
      4'h7: hex_pat = 8'hF8;
      4'h8: hex_pat = 8'h80;
      4'h9: hex_pat = 8'h90;
      4'hA: hex_pat = 8'h88;
      4'hB: hex_pat = 8'h83;
      4'hC: hex_pat = 8'hC6;
      4'hD: hex_pat = 8'hA1;
      4'hE: hex_pat = 8'h86;
      4'hF: hex_pat = 8'h8E;
      default: hex_pat = 8'hFF;
    endcase
    pattern = ctrl_raw ? ~cur_byte
                       : {hex_pat[7] & ~ctrl_dp[digit], hex_pat[6:0]};
  end

  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      anodes   <= 4'hF;
      sieteseg <= 8'hFF;
    end else if (ctrl_en) begin
      anodes   <= ~(4'b0001 << digit);
      sieteseg <= pattern;
    end else begin
      anodes   <= 4'hF;
      sieteseg <= 8'hFF;
    end
  end

endmodule

// File: doc/axi_sevenseg_slave.md
# axi_sevenseg_slave

AXI4-Lite slave peripheral driving a 4-digit multiplexed seven-segment display: the responder end of the register-write/read bus protocol used by the lab CIP test benches. It holds a small register file (control, digit data, scan prescaler, status), serves single-beat AXI4-Lite reads and writes, and continuously scans the four digits onto a shared active-low segment bus. It sits between the processor-side AXI interconnect (or the bench's bus-functional master) and the board's display pins.

## Interface
- C_S00_AXI_DATA_WIDTH, 32, data bus width (only 32 supported)
- C_S00_AXI_ADDR_WIDTH, 4, byte address width; 4 word registers at offsets 0x0, 0x4, 0x8, 0xC
- s00_axi_aclk  in  1  single clock, all logic rising-edge
- s00_axi_areset  in  1  reset, asynchronous, active-high
- s00_axi_awaddr  in  4  write address
- s00_axi_awprot  in  3  ignored
- s00_axi_awvalid / s00_axi_awready  in / out  1  write address handshake
- s00_axi_wdata  in  32  write data
- s00_axi_wstrb  in  4  byte enables
- s00_axi_wvalid / s00_axi_wready  in / out  1  write data handshake
- s00_axi_bresp  out  2  always 2'b00 (OKAY)
- s00_axi_bvalid / s00_axi_bready  out / in  1  write response handshake
- s00_axi_araddr  in  4  read address
- s00_axi_arprot  in  3  ignored
- s00_axi_arvalid / s00_axi_arready  in / out  1  read address handshake
- s00_axi_rdata  out  32  read data
- s00_axi_rresp  out  2  always 2'b00
- s00_axi_rvalid / s00_axi_rready  out / in  1  read data handshake
- sieteseg  out  8  segments {dp,g,f,e,d,c,b,a}, active-low
- anodes  out  4  digit selects, active-low, one-hot-low when enabled

## Operation
- Registers (word index = addr[3:2]):
  - 0 CTRL: [0] enable, [1] raw mode, [7:4] decimal points per digit (hex mode); other bits read 0.
  - 1 DIGITS: hex mode uses nibble k = DIGITS[4k+3:4k] for digit k; raw mode uses byte k as active-high segment pattern (output inverted).
  - 2 PRESCALE: [15:0] scan divider; other bits read 0.
  - 3 STATUS (read-only; writes accepted, data dropped): [1:0] current digit, [15:8] accepted-write count (wraps 255→0).
- Writes honour wstrb per byte; write count increments on every accepted write, including to STATUS.
- Hex decode (active-low, dp=1): 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90, A 88, B 83, C C6, D A1, E 86, F 8E; dp bit cleared when CTRL[4+k]=1.
- Scan: 16-bit counter; tick when counter == PRESCALE, counter then clears; PRESCALE=0 → tick every cycle. Each tick advances digit 0→1→2→3→0. Counter and digit run only while enable=1; clearing enable freezes them.
- Outputs registered: enabled → anodes = ~(1<<digit), sieteseg = pattern of that digit; disabled → anodes 4'hF, sieteseg 8'hFF.

## Timing
- Reset: all registers 0; awready, wready, bvalid, arready, rvalid, rdata 0; sieteseg 8'hFF, anodes 4'hF. Asserting reset mid-transaction drops pending bvalid/rvalid immediately.
- Write: awready and wready rise together one cycle after both awvalid and wvalid are high with awready=0 and bvalid=0; both are high for exactly one cycle. Register update and bvalid=1 occur on the edge where awready&awvalid&wready&wvalid. bvalid holds until bready; no new write accepted while bvalid=1. awvalid without wvalid (or vice versa) waits.
- Read: arready pulses one cycle after arvalid with arready=0, rvalid=0; rdata latched and rvalid=1 on the handshake edge; held until rready.
- Read and write channels independent; simultaneous read of a register written on the same edge returns the old value.
- Display outputs update one cycle after a tick or a register change.

## Test plan
- Reset 10 cycles, release → sieteseg 8'hFF, anodes 4'hF, all valids/readies 0; read all 4 regs → 0.
- Write CTRL=0x1, PRESCALE=0, DIGITS=0x00003210 → anodes cycle E,D,B,7 each cycle with sieteseg C0,F9,A4,B0.
- Write DIGITS=0xFFFFFFFF with wstrb=4'b0010 → readback 0x0000FF00; STATUS[15:8] = number of writes issued.
- Hold bready=0 after a write → bvalid stays 1, second write's awready stays 0 until bready.
- PRESCALE=3, CTRL=0x13 (raw, enable) → digit advances every 4 cycles; CTRL=0 → outputs FF/F, STATUS[1:0] frozen.
- Assert reset while rvalid=1 and rready=0 → rvalid drops asynchronously, registers return 0.
